// File: rtl/if_req_arbiter_if.sv
// Request/response bundle shared by the fetch, prefetch and icache ports.
// The master drives the request; the slave answers with accept, data-ready and data.
interface if_req_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output valid, addr, input  addr_ok, data_ok, rdata);
    modport slave  (input  valid, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_req_arbiter.sv
// Fixed-priority arbiter (fetch over prefetch) onto a single icache port.
// An address is held stable until it is accepted; returned data is routed by an owner FIFO with flush cancel.
module if_req_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    if_req_arbiter_if.slave  f,
    if_req_arbiter_if.slave  p,
    if_req_arbiter_if.master c,
    output logic             c_uncached,
    input  logic             flush,
    output logic             busy,
    output logic             err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic { OWN_F = 1'b0, OWN_P = 1'b1 } owner_e;
    typedef enum logic { ST_OPEN = 1'b0, ST_LOCKED = 1'b1 } lock_e;

    lock_e           state_q, state_d;
    owner_e          req_own_q, req_own_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [DEPTH-1:0] own_q, own_d;
    logic [DEPTH-1:0] cancel_q, cancel_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    owner_e          grant;
    logic            locked, accept, pop, deliver, head_is_p;

    assign locked    = (state_q == ST_LOCKED);
    assign grant     = locked ? req_own_q : (f.valid ? OWN_F : OWN_P);
    assign c.addr    = locked ? req_addr_q : (f.valid ? f.addr : p.addr);
    // Gated with resetn so no request leaks out while reset is held.
    assign c.valid   = resetn & (f.valid | p.valid | locked) & (count_q < CW'(DEPTH));
    assign accept    = c.valid & c.addr_ok;
    assign f.addr_ok = accept & (grant == OWN_F);
    assign p.addr_ok = accept & (grant == OWN_P);

    assign pop       = c.data_ok & (count_q != '0);
    assign head_is_p = own_q[rptr_q];
    assign deliver   = pop & ~cancel_q[rptr_q] & ~flush;
    assign f.data_ok = deliver & ~head_is_p;
    assign p.data_ok = deliver & head_is_p;
    assign f.rdata   = f.data_ok ? c.rdata : '0;
    assign p.rdata   = p.data_ok ? c.rdata : '0;

    assign c_uncached = 1'b0;
    assign busy       = (count_q != '0) | locked;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        req_own_d  = req_own_q;
        req_addr_d = req_addr_q;
        own_d      = own_q;
        cancel_d   = cancel_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q + CW'(accept) - CW'(pop);
        err_d      = err_q | (c.data_ok & (count_q == '0));

        if (accept) begin
            state_d = ST_OPEN;
        end else if (c.valid && !locked) begin
            state_d    = ST_LOCKED;
            req_own_d  = grant;
            req_addr_d = c.addr;
        end

        if (accept) begin
            own_d[wptr_q]    = (grant == OWN_P);
            cancel_d[wptr_q] = 1'b0;
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
        // Marking every slot also covers a same-cycle push; unused slots are rewritten on push.
        if (flush) begin
            cancel_d = '1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_OPEN;
            req_own_q  <= OWN_F;
            req_addr_q <= '0;
            own_q      <= '0;
            cancel_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_own_q  <= req_own_d;
            req_addr_q <= req_addr_d;
            own_q      <= own_d;
            cancel_q   <= cancel_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_if_req_arbiter.sv
// Directed bench for if_req_arbiter: accepted requests push an expected return onto a
// scoreboard, and each icache data return pops and checks the routed outputs.
module tb_if_req_arbiter;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;
    logic c_uncached, busy, err;

    if_req_arbiter_if f_bus ();
    if_req_arbiter_if p_bus ();
    if_req_arbiter_if c_bus ();

    if_req_arbiter #(.DEPTH(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .f          (f_bus),
        .p          (p_bus),
        .c          (c_bus),
        .c_uncached (c_uncached),
        .flush      (flush),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_p;
        logic [31:0] data;
        logic        canc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic settle(); #4; endtask
    task automatic tick(); @(posedge clk); #1; endtask

    task automatic idle();
        f_bus.valid   = 1'b0;
        p_bus.valid   = 1'b0;
        c_bus.addr_ok = 1'b0;
        c_bus.data_ok = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic push_exp(input logic is_p, input logic [31:0] data, input logic canc);
        exp_t e;
        e.is_p = is_p;
        e.data = data;
        e.canc = canc;
        sb.push_back(e);
    endtask

    task automatic cancel_all();
        foreach (sb[i]) sb[i].canc = 1'b1;
    endtask

    task automatic drive_ret();
        c_bus.data_ok = 1'b1;
        c_bus.rdata   = (sb.size() != 0) ? sb[0].data : 32'hdead_beef;
    endtask

    task automatic check_ret(input string tag);
        exp_t e;
        logic sel_f, sel_p;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty got 0 want 1", tag);
        end else begin
            e     = sb.pop_front();
            sel_f = !e.canc && !e.is_p;
            sel_p = !e.canc && e.is_p;
            chk({tag, "_fdok"}, f_bus.data_ok, sel_f);
            chk({tag, "_pdok"}, p_bus.data_ok, sel_p);
            chk({tag, "_frd"},  f_bus.rdata, sel_f ? e.data : 32'h0);
            chk({tag, "_prd"},  p_bus.rdata, sel_p ? e.data : 32'h0);
        end
    endtask

    task automatic ret_cycle(input string tag);
        drive_ret();
        settle();
        check_ret(tag);
        tick();
        c_bus.data_ok = 1'b0;
    endtask

    initial begin
        f_bus.addr  = '0;
        p_bus.addr  = '0;
        c_bus.rdata = '0;
        idle();
        f_bus.valid   = 1'b1;
        p_bus.valid   = 1'b1;
        c_bus.addr_ok = 1'b1;
        c_bus.data_ok = 1'b1;
        #12;
        chk("rst_cvalid", c_bus.valid, 1'b0);
        chk("rst_faok",   f_bus.addr_ok, 1'b0);
        chk("rst_paok",   p_bus.addr_ok, 1'b0);
        chk("rst_fdok",   f_bus.data_ok, 1'b0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_err",    err, 1'b0);
        idle();
        tick();
        resetn = 1'b1;

        // Contention: fetch wins, accepted on the first edge after reset.
        f_bus.valid = 1'b1; p_bus.valid = 1'b1;
        f_bus.addr  = 32'h1c00_0000; p_bus.addr = 32'h1c00_0100;
        c_bus.addr_ok = 1'b1;
        settle();
        chk("cont_caddr", c_bus.addr, 32'h1c00_0000);
        chk("cont_faok",  f_bus.addr_ok, 1'b1);
        chk("cont_paok",  p_bus.addr_ok, 1'b0);
        chk("cont_unc",   c_uncached, 1'b0);
        push_exp(1'b0, 32'h0280_0000, 1'b0);
        tick();
        idle();
        ret_cycle("cont_ret");
        settle();
        chk("cont_busy", busy, 1'b0);
        chk("cont_err",  err, 1'b0);
        tick();

        // Lock: held prefetch is not pre-empted by a later fetch.
        p_bus.valid = 1'b1; p_bus.addr = 32'h1c00_0040;
        settle();
        chk("lock_c1_addr", c_bus.addr, 32'h1c00_0040);
        chk("lock_c1_cv",   c_bus.valid, 1'b1);
        chk("lock_c1_paok", p_bus.addr_ok, 1'b0);
        tick();
        f_bus.valid = 1'b1; f_bus.addr = 32'h1c00_0080;
        settle();
        chk("lock_c2_addr", c_bus.addr, 32'h1c00_0040);
        chk("lock_c2_faok", f_bus.addr_ok, 1'b0);
        tick();
        settle();
        chk("lock_c3_addr", c_bus.addr, 32'h1c00_0040);
        chk("lock_c3_busy", busy, 1'b1);
        tick();
        c_bus.addr_ok = 1'b1;
        settle();
        chk("lock_acc_paok", p_bus.addr_ok, 1'b1);
        chk("lock_acc_faok", f_bus.addr_ok, 1'b0);
        chk("lock_acc_addr", c_bus.addr, 32'h1c00_0040);
        push_exp(1'b1, 32'h1111_0040, 1'b0);
        tick();
        p_bus.valid = 1'b0;
        settle();
        chk("lock_next_addr", c_bus.addr, 32'h1c00_0080);
        chk("lock_next_faok", f_bus.addr_ok, 1'b1);
        push_exp(1'b0, 32'h2222_0080, 1'b0);
        tick();
        idle();
        ret_cycle("lock_ret0");
        ret_cycle("lock_ret1");

        // Full: no bypass of a same-cycle pop into c_valid.
        f_bus.valid = 1'b1; c_bus.addr_ok = 1'b1;
        f_bus.addr = 32'h1c00_0100;
        settle(); chk("full_a0", f_bus.addr_ok, 1'b1); push_exp(1'b0, 32'h3333_0100, 1'b0); tick();
        f_bus.addr = 32'h1c00_0104;
        settle(); chk("full_a1", f_bus.addr_ok, 1'b1); push_exp(1'b0, 32'h3333_0104, 1'b0); tick();
        f_bus.addr = 32'h1c00_0108;
        settle();
        chk("full_cv",   c_bus.valid, 1'b0);
        chk("full_faok", f_bus.addr_ok, 1'b0);
        chk("full_busy", busy, 1'b1);
        tick();
        drive_ret();
        settle();
        chk("full_nobyp_cv", c_bus.valid, 1'b0);
        check_ret("full_ret0");
        tick();
        c_bus.data_ok = 1'b0;
        settle();
        chk("full_reopen_cv",   c_bus.valid, 1'b1);
        chk("full_reopen_faok", f_bus.addr_ok, 1'b1);
        push_exp(1'b0, 32'h3333_0108, 1'b0);
        tick();
        idle();
        ret_cycle("full_ret1");
        ret_cycle("full_ret2");

        // Flush with two requests outstanding.
        f_bus.valid = 1'b1; f_bus.addr = 32'h1c00_0200; c_bus.addr_ok = 1'b1;
        settle(); chk("fl_a0", f_bus.addr_ok, 1'b1); push_exp(1'b0, 32'h4444_0200, 1'b0); tick();
        f_bus.valid = 1'b0; p_bus.valid = 1'b1; p_bus.addr = 32'h1c00_0240;
        settle(); chk("fl_a1", p_bus.addr_ok, 1'b1); push_exp(1'b1, 32'h4444_0240, 1'b0); tick();
        idle();
        flush = 1'b1;
        settle();
        chk("fl_busy", busy, 1'b1);
        cancel_all();
        tick();
        flush = 1'b0;
        ret_cycle("fl_ret0");
        ret_cycle("fl_ret1");
        settle();
        chk("fl_idle_busy", busy, 1'b0);
        tick();
        f_bus.valid = 1'b1; f_bus.addr = 32'h1c00_0280; c_bus.addr_ok = 1'b1;
        settle(); chk("fl_after_faok", f_bus.addr_ok, 1'b1); push_exp(1'b0, 32'h5555_0280, 1'b0); tick();
        idle();
        ret_cycle("fl_after_ret");

        // Flush coinciding with a push and a pop.
        f_bus.valid = 1'b1; f_bus.addr = 32'h1c00_0300; c_bus.addr_ok = 1'b1;
        settle(); chk("fpp_a0", f_bus.addr_ok, 1'b1); push_exp(1'b0, 32'h6666_0300, 1'b0); tick();
        f_bus.addr = 32'h1c00_0304;
        flush = 1'b1;
        drive_ret();
        settle();
        chk("fpp_faok", f_bus.addr_ok, 1'b1);
        cancel_all();
        check_ret("fpp_pop");
        push_exp(1'b0, 32'h6666_0304, 1'b1);
        tick();
        idle();
        settle();
        chk("fpp_busy", busy, 1'b1);
        tick();
        ret_cycle("fpp_late");
        settle();
        chk("fpp_busy_end", busy, 1'b0);
        tick();

        // Stray data return sets a sticky err; async reset clears it at once.
        c_bus.data_ok = 1'b1; c_bus.rdata = 32'h0000_0bad;
        settle();
        chk("err_fdok", f_bus.data_ok, 1'b0);
        chk("err_pdok", p_bus.data_ok, 1'b0);
        tick();
        c_bus.data_ok = 1'b0;
        settle(); chk("err_set", err, 1'b1); tick();
        settle(); chk("err_held", err, 1'b1); chk("err_busy", busy, 1'b0);
        f_bus.valid = 1'b1; f_bus.addr = 32'h1c00_0400;
        tick();
        chk("err_lock_busy", busy, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_err",  err, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cv",   c_bus.valid, 1'b0);
        idle();
        sb.delete();
        tick();
        resetn = 1'b1;
        settle();
        chk("post_rst_busy", busy, 1'b0);
        c_bus.data_ok = 1'b1;
        tick();
        c_bus.data_ok = 1'b0;
        settle();
        chk("post_rst_err", err, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_req_arbiter.md
IF_REQ_ARBITER -- requirements
Module: if_req_arbiter

Interface
REQ-001 Parameter: DEPTH, default 2, maximum number of outstanding icache requests (address accepted, data not yet returned).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 f_valid / f_addr  input  1 / 32  demand-fetch request and its address, driven from IF0.
REQ-005 f_addr_ok / f_data_ok / f_rdata  output  1 / 1 / 32  demand-fetch address accept, data return and instruction word.
REQ-006 p_valid / p_addr  input  1 / 32  prefetch request and its address.
REQ-007 p_addr_ok / p_data_ok / p_rdata  output  1 / 1 / 32  prefetch address accept, data return and data word.
REQ-008 flush  input  1  pipeline flush; cancels every request that is in flight.
REQ-009 c_valid / c_addr / c_uncached  output  1 / 32 / 1  icache request port; c_uncached is tied to 0.
REQ-010 c_addr_ok / c_data_ok / c_rdata  input  1 / 1 / 32  icache address accept, data return and data word.
REQ-011 busy  output  1  high while any request is outstanding or an address is locked.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 Arbitration uses fixed priority: the fetch requester wins over the prefetch requester whenever the port is unlocked.
REQ-014 c_valid = (f_valid | p_valid | lock) & (count < DEPTH), where count is the number of outstanding requests.
REQ-015 A grant with c_valid=1 and c_addr_ok=0 sets lock; the winner and its address are latched in a request register.
REQ-016 While lock=1, c_addr and the grant come from the request register: no re-arbitration, and a newly arriving f_valid does not pre-empt a held prefetch.
REQ-017 lock clears in the cycle where c_valid & c_addr_ok.
REQ-018 flush does not withdraw a locked address; the request completes its address handshake and is then cancelled per REQ-022.
REQ-019 f_addr_ok = c_valid & c_addr_ok & grant==F; p_addr_ok = c_valid & c_addr_ok & grant==P; both are combinational with zero latency.
REQ-020 Owner FIFO, DEPTH entries of {owner, cancel}: a push {grant, 0} occurs on every c_valid & c_addr_ok; a pop occurs on every c_data_ok.
REQ-021 On pop, c_data_ok/c_rdata route combinationally to the owner's data_ok/rdata, unless the head cancel bit is set, in which case both data_ok outputs stay 0.
REQ-022 When flush=1, the cancel bit is set on every entry that remains after this cycle, including an entry pushed in the same cycle.
REQ-023 When flush=1, an entry popped in the same cycle is still suppressed, i.e. neither data_ok output asserts.
REQ-024 A simultaneous push and pop leaves count unchanged; the FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 When count==DEPTH, c_valid=0 and both addr_ok outputs are 0; a pop in that cycle does not raise c_valid until the next cycle (no bypass).
REQ-026 c_data_ok while count==0 is ignored, sets err, and changes no other state.
REQ-027 c_addr_ok with c_valid=0 is ignored.
REQ-028 rdata outputs not selected by REQ-021 are driven to 0.
REQ-029 busy = (count != 0) | lock.

Reset
REQ-030 resetn=0 asynchronously clears count, FIFO pointers, all cancel bits, lock, the request register and err.
REQ-031 During reset c_valid, all addr_ok/data_ok outputs, busy and err read 0.
REQ-032 Reset asserted mid-operation discards all in-flight requests; c_data_ok arriving after reset release with count==0 sets err per REQ-026.
REQ-033 The first request may be issued in the first rising edge after resetn deasserts.

Verification
REQ-034 Contention: f_valid=1, p_valid=1, c_addr_ok=1, f_addr=0x1c000000 -> c_addr=0x1c000000, f_addr_ok=1, p_addr_ok=0; one cycle later c_data_ok=1, c_rdata=0x02800000 -> f_data_ok=1, f_rdata=0x02800000, p_data_ok=0.
REQ-035 Lock: p_valid=1 with p_addr=0x1c000040, c_addr_ok=0 for 3 cycles, f_valid raised in cycle 2 -> c_addr stays 0x1c000040 for all 3 cycles; on c_addr_ok=1, p_addr_ok=1, and fetch is granted the next cycle.
REQ-036 Full: two fetch requests accepted with no data return -> c_valid=0 and f_addr_ok=0; on one c_data_ok, c_valid=1 again the following cycle.
REQ-037 Flush: two requests outstanding, flush=1 for one cycle -> the next two c_data_ok produce no f_data_ok/p_data_ok; a fetch accepted after the flush returns normally.
REQ-038 Flush with push and pop: flush in the same cycle as a push and a pop -> the popped data and the pushed request are both suppressed; count is unchanged.
REQ-039 Error and reset: c_data_ok with count==0 -> err=1, held; resetn pulsed low asynchronously mid-request -> err=0, busy=0, c_valid=0 immediately.
